// File: rtl/egress_cpl_gen_if.sv
// Bundle of the request-side handshake, the completer ID and the TX AXI-stream
// toward the PCIe core, shared by egress_cpl_gen and whatever sits around it.
//
// Signal groups:
//   req_*            : parsed 1-DW MRd request in (valid/ready handshake)
//   cfg_completer_id : bus/dev/func of this endpoint
//   m_axis_tx_*      : 64-bit TX stream out, tuser tied off
//
// Modports:
//   master : the completion generator (drives req_ready and the TX stream)
//   slave  : the surrounding logic (drives requests, completer ID and tready)
interface egress_cpl_gen_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_ur;
   logic [7:0]  req_tag;
   logic [15:0] req_rid;
   logic [2:0]  req_tc;
   logic [1:0]  req_attr;
   logic [6:0]  req_laddr;
   logic [31:0] req_data;
   logic [15:0] cfg_completer_id;

   logic        m_axis_tx_tready;
   logic [63:0] m_axis_tx_tdata;
   logic [7:0]  m_axis_tx_tkeep;
   logic        m_axis_tx_sop;
   logic        m_axis_tx_eop;
   logic        m_axis_tx_tvalid;
   logic [3:0]  m_axis_tx_tuser;

   modport master (
      input  req_valid, req_ur, req_tag, req_rid, req_tc, req_attr, req_laddr, req_data,
      input  cfg_completer_id,
      input  m_axis_tx_tready,
      output req_ready,
      output m_axis_tx_tdata, m_axis_tx_tkeep, m_axis_tx_sop, m_axis_tx_eop,
      output m_axis_tx_tvalid, m_axis_tx_tuser
   );

   modport slave (
      output req_valid, req_ur, req_tag, req_rid, req_tc, req_attr, req_laddr, req_data,
      output cfg_completer_id,
      output m_axis_tx_tready,
      input  req_ready,
      input  m_axis_tx_tdata, m_axis_tx_tkeep, m_axis_tx_sop, m_axis_tx_eop,
      input  m_axis_tx_tvalid, m_axis_tx_tuser
   );
endinterface

// File: rtl/egress_cpl_gen.sv
// Completion generator for 1-DW memory reads. Each accepted request produces a
// 3DW-header completion on a 64-bit TX stream in exactly two beats:
//   beat0 : {DW1, DW0}           sop, full keep
//   beat1 : {DW3, DW2}  (CplD)   eop, full keep
//           {32'd0, DW2} (UR)    eop, low half keep
// A new request may be accepted in the cycle beat1 is consumed, so completions
// stream back to back without idle cycles.
//
// Ports:
//   clk     : system clock, rising edge
//   rst     : asynchronous active-high reset
//   bus     : request / completer ID / TX stream bundle (master view)
//   cpl_cnt : completions fully sent, wraps modulo 2^CNT_W
module egress_cpl_gen #(
   parameter int unsigned CNT_W = 16
) (
   input  logic                clk,
   input  logic                rst,
   egress_cpl_gen_if.master    bus,
   output logic [CNT_W-1:0]    cpl_cnt
);

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StBeat0 = 2'd1,
      StBeat1 = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic              tvalid_q, tvalid_d;
   logic [63:0]       tdata_q, tdata_d;
   logic [7:0]        tkeep_q, tkeep_d;
   logic              sop_q, sop_d;
   logic              eop_q, eop_d;
   // Second-beat content captured at the handshake.
   logic [31:0]       dw2_q, dw2_d;
   logic [31:0]       data_q, data_d;
   logic              ur_q, ur_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic              req_ready;
   logic              hs;
   logic              tready;
   logic [2:0]        fmt;
   logic [9:0]        len;
   logic [2:0]        status;
   logic [31:0]       dw0;
   logic [31:0]       dw1;
   logic [31:0]       dw2_new;

   assign tready = bus.m_axis_tx_tready;

   // Ready is held low while reset is asserted even though the state is already
   // forced to idle.
   assign req_ready = !rst && ((state_q == StIdle) ||
                               ((state_q == StBeat1) && tready));
   assign hs        = bus.req_valid && req_ready;

   // Header dwords built from the live request fields; they are only consumed
   // on the handshake edge, which is where they get captured.
   assign fmt     = bus.req_ur ? 3'b000 : 3'b010;
   assign len     = bus.req_ur ? 10'd0 : 10'd1;
   assign status  = bus.req_ur ? 3'b001 : 3'b000;
   assign dw0     = {fmt, 5'b01010, 1'b0, bus.req_tc, 6'b0, bus.req_attr, 2'b0, len};
   assign dw1     = {bus.cfg_completer_id, status, 1'b0, 12'd4};
   assign dw2_new = {bus.req_rid, bus.req_tag, 1'b0, bus.req_laddr};

   always_comb begin
      state_d  = state_q;
      tvalid_d = tvalid_q;
      tdata_d  = tdata_q;
      tkeep_d  = tkeep_q;
      sop_d    = sop_q;
      eop_d    = eop_q;
      dw2_d    = dw2_q;
      data_d   = data_q;
      ur_d     = ur_q;
      cnt_d    = cnt_q;

      unique case (state_q)
         StIdle: begin
            if (hs) begin
               state_d  = StBeat0;
               tvalid_d = 1'b1;
               tdata_d  = {dw1, dw0};
               tkeep_d  = 8'hFF;
               sop_d    = 1'b1;
               eop_d    = 1'b0;
               dw2_d    = dw2_new;
               data_d   = bus.req_data;
               ur_d     = bus.req_ur;
            end
         end
         StBeat0: begin
            if (tready) begin
               state_d  = StBeat1;
               tdata_d  = ur_q ? {32'd0, dw2_q} : {data_q, dw2_q};
               tkeep_d  = ur_q ? 8'h0F : 8'hFF;
               sop_d    = 1'b0;
               eop_d    = 1'b1;
            end
         end
         StBeat1: begin
            if (tready) begin
               cnt_d = cnt_q + CNT_W'(1);
               if (hs) begin
                  // Next completion's first beat follows immediately.
                  state_d  = StBeat0;
                  tvalid_d = 1'b1;
                  tdata_d  = {dw1, dw0};
                  tkeep_d  = 8'hFF;
                  sop_d    = 1'b1;
                  eop_d    = 1'b0;
                  dw2_d    = dw2_new;
                  data_d   = bus.req_data;
                  ur_d     = bus.req_ur;
               end else begin
                  state_d  = StIdle;
                  tvalid_d = 1'b0;
                  tdata_d  = 64'd0;
                  tkeep_d  = 8'h00;
                  sop_d    = 1'b0;
                  eop_d    = 1'b0;
               end
            end
         end
         default: begin
            state_d  = StIdle;
            tvalid_d = 1'b0;
            tdata_d  = 64'd0;
            tkeep_d  = 8'h00;
            sop_d    = 1'b0;
            eop_d    = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         tvalid_q <= 1'b0;
         tdata_q  <= 64'd0;
         tkeep_q  <= 8'h00;
         sop_q    <= 1'b0;
         eop_q    <= 1'b0;
         dw2_q    <= 32'd0;
         data_q   <= 32'd0;
         ur_q     <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         tvalid_q <= tvalid_d;
         tdata_q  <= tdata_d;
         tkeep_q  <= tkeep_d;
         sop_q    <= sop_d;
         eop_q    <= eop_d;
         dw2_q    <= dw2_d;
         data_q   <= data_d;
         ur_q     <= ur_d;
         cnt_q    <= cnt_d;
      end
   end

   assign bus.req_ready        = req_ready;
   assign bus.m_axis_tx_tvalid = tvalid_q;
   assign bus.m_axis_tx_tdata  = tdata_q;
   assign bus.m_axis_tx_tkeep  = tkeep_q;
   assign bus.m_axis_tx_sop    = sop_q;
   assign bus.m_axis_tx_eop    = eop_q;
   assign bus.m_axis_tx_tuser  = 4'd0;
   assign cpl_cnt              = cnt_q;

endmodule

// File: tb/tb_egress_cpl_gen.sv
module tb_egress_cpl_gen;

   localparam int unsigned CNT_W = 4;

   typedef struct packed {
      logic [63:0] data;
      logic [7:0]  keep;
      logic        sop;
      logic        eop;
   } beat_t;

   logic             clk;
   logic             rst;
   logic [CNT_W-1:0] cpl_cnt;

   egress_cpl_gen_if bus_if ();

   egress_cpl_gen #(.CNT_W(CNT_W)) dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus_if),
      .cpl_cnt (cpl_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned      n_total = 0;
   int unsigned      n_bad   = 0;
   beat_t            exp_q[$];
   logic [CNT_W-1:0] cnt_m;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference: the two beats of a completion, assembled from header field
   // positions with plain arithmetic.
   task automatic push_cpl(input bit ur, input logic [7:0] tag, input logic [15:0] rid,
                           input logic [2:0] tc, input logic [1:0] attr,
                           input logic [6:0] laddr, input logic [31:0] data,
                           input logic [15:0] cid);
      logic [31:0] dw0, dw1, dw2;
      beat_t       b0, b1;
      dw0 = ((ur ? 32'd0 : 32'd2) << 29) | (32'd10 << 24) | (32'(tc) << 20)
            | (32'(attr) << 12) | (ur ? 32'd0 : 32'd1);
      dw1 = (32'(cid) << 16) | ((ur ? 32'd1 : 32'd0) << 13) | 32'd4;
      dw2 = (32'(rid) << 16) | (32'(tag) << 8) | 32'(laddr);
      b0.data = {dw1, dw0};
      b0.keep = 8'hFF;
      b0.sop  = 1'b1;
      b0.eop  = 1'b0;
      b1.data = ur ? {32'd0, dw2} : {data, dw2};
      b1.keep = ur ? 8'h0F : 8'hFF;
      b1.sop  = 1'b0;
      b1.eop  = 1'b1;
      exp_q.push_back(b0);
      exp_q.push_back(b1);
   endtask

   // Called just after a falling edge with the inputs for the next rising edge
   // already applied: checks outputs, then advances the model across that edge.
   task automatic eval();
      bit    exp_rdy;
      beat_t h;
      #1;
      if (rst) begin
         chk("rst_ready", 64'(bus_if.req_ready), 64'd0);
         chk("rst_tvalid", 64'(bus_if.m_axis_tx_tvalid), 64'd0);
         chk("rst_sop_eop", 64'({bus_if.m_axis_tx_sop, bus_if.m_axis_tx_eop}), 64'd0);
         chk("rst_tdata", bus_if.m_axis_tx_tdata, 64'd0);
         chk("rst_tkeep", 64'(bus_if.m_axis_tx_tkeep), 64'd0);
         chk("rst_cnt", 64'(cpl_cnt), 64'd0);
         exp_q.delete();
         cnt_m = '0;
         return;
      end
      exp_rdy = (exp_q.size() == 0) || (exp_q.size() == 1 && bus_if.m_axis_tx_tready);
      chk("req_ready", 64'(bus_if.req_ready), 64'(exp_rdy));
      chk("tvalid", 64'(bus_if.m_axis_tx_tvalid), 64'(exp_q.size() != 0));
      chk("tuser", 64'(bus_if.m_axis_tx_tuser), 64'd0);
      chk("cpl_cnt", 64'(cpl_cnt), 64'(cnt_m));
      if (bus_if.m_axis_tx_tvalid && exp_q.size() != 0) begin
         h = exp_q[0];
         chk("tdata", bus_if.m_axis_tx_tdata, h.data);
         chk("tkeep", 64'(bus_if.m_axis_tx_tkeep), 64'(h.keep));
         chk("sop", 64'(bus_if.m_axis_tx_sop), 64'(h.sop));
         chk("eop", 64'(bus_if.m_axis_tx_eop), 64'(h.eop));
         if (bus_if.m_axis_tx_tready) begin
            if (h.eop) cnt_m = cnt_m + 1'b1;
            void'(exp_q.pop_front());
         end
      end
      if (bus_if.req_valid && exp_rdy)
         push_cpl(bus_if.req_ur, bus_if.req_tag, bus_if.req_rid, bus_if.req_tc,
                  bus_if.req_attr, bus_if.req_laddr, bus_if.req_data,
                  bus_if.cfg_completer_id);
   endtask

   task automatic drive(input bit v, input bit tr);
      bus_if.req_valid        = v;
      bus_if.m_axis_tx_tready = tr;
      eval();
      @(negedge clk);
   endtask

   task automatic rand_fields(input bit ur);
      bus_if.req_ur           = ur;
      bus_if.req_tag          = 8'($urandom);
      bus_if.req_rid          = 16'($urandom);
      bus_if.req_tc           = 3'($urandom);
      bus_if.req_attr         = 2'($urandom);
      bus_if.req_laddr        = {5'($urandom), 2'b00};
      bus_if.req_data         = $urandom;
      bus_if.cfg_completer_id = 16'($urandom);
   endtask

   task automatic drain();
      for (int i = 0; i < 8 && exp_q.size() != 0; i++) drive(1'b0, 1'b1);
      if (exp_q.size() != 0) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic send_one(input bit ur);
      rand_fields(ur);
      drive(1'b1, 1'b1);
      drain();
   endtask

   logic [63:0] held;
   int          beats, first_b, last_b, hs_n;
   logic [CNT_W-1:0] cnt0;

   initial begin
      rst = 1'b1;
      bus_if.req_valid = 1'b0;
      bus_if.m_axis_tx_tready = 1'b0;
      rand_fields(1'b0);
      cnt_m = '0;
      @(negedge clk);
      drive(1'b0, 1'b1);
      drive(1'b1, 1'b1);
      rst = 1'b0;
      drive(1'b0, 1'b1);

      // Single CplD with known fields.
      bus_if.req_ur = 1'b0; bus_if.req_tag = 8'h05; bus_if.req_rid = 16'h0100;
      bus_if.req_tc = 3'd0; bus_if.req_attr = 2'd0; bus_if.req_laddr = 7'h28;
      bus_if.req_data = 32'hDEADBEEF; bus_if.cfg_completer_id = 16'h0200;
      drive(1'b1, 1'b1);
      chk("cpld_beat0", bus_if.m_axis_tx_tdata, 64'h0200_0004_4A00_0001);
      drive(1'b0, 1'b1);
      chk("cpld_beat1", bus_if.m_axis_tx_tdata, 64'hDEADBEEF_0100_0528);
      chk("cpld_eop", 64'(bus_if.m_axis_tx_eop), 64'd1);
      drive(1'b0, 1'b1);
      chk("cpld_cnt", 64'(cpl_cnt), 64'd1);

      // Unsupported request.
      bus_if.req_ur = 1'b1; bus_if.req_tag = 8'h07;
      drive(1'b1, 1'b1);
      chk("ur_dw0", 64'(bus_if.m_axis_tx_tdata[31:0]), 64'h0A00_0000);
      chk("ur_status", 64'(bus_if.m_axis_tx_tdata[47:45]), 64'd1);
      drive(1'b0, 1'b1);
      chk("ur_tkeep", 64'(bus_if.m_axis_tx_tkeep), 64'h0F);
      chk("ur_eop", 64'(bus_if.m_axis_tx_eop), 64'd1);
      drain();

      // Backpressure in the first beat.
      rand_fields(1'b0);
      drive(1'b1, 1'b1);
      held = bus_if.m_axis_tx_tdata;
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 1'b0);
         chk("bp_hold", bus_if.m_axis_tx_tdata, held);
         chk("bp_ready", 64'(bus_if.req_ready), 64'd0);
      end
      drive(1'b0, 1'b1);
      drain();

      // Back-to-back: three requests with valid held high.
      beats = 0; first_b = -1; last_b = -1; hs_n = 0; cnt0 = cnt_m;
      rand_fields(1'b0);
      for (int i = 0; i < 9; i++) begin
         bit v, rdy;
         v   = (hs_n < 3);
         rdy = (exp_q.size() == 0) || (exp_q.size() == 1);
         drive(v, 1'b1);
         if (v && rdy) begin
            hs_n++;
            rand_fields(hs_n == 2);
         end
         if (bus_if.m_axis_tx_tvalid) begin
            beats++;
            if (first_b < 0) first_b = i;
            last_b = i;
         end
      end
      chk("b2b_beats", 64'(beats), 64'd6);
      chk("b2b_contig", 64'(last_b - first_b + 1), 64'd6);
      chk("b2b_cnt", 64'(cpl_cnt - cnt0), 64'd3);

      // Counter wrap.
      rst = 1'b1;
      drive(1'b0, 1'b1);
      rst = 1'b0;
      for (int i = 0; i < 15; i++) send_one(1'($urandom));
      chk("wrap_pre", 64'(cpl_cnt), 64'd15);
      send_one(1'b0);
      chk("wrap_zero", 64'(cpl_cnt), 64'd0);

      // Random traffic with random backpressure.
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(1, 0) == 1) rand_fields(1'($urandom));
         drive(1'($urandom), $urandom_range(9, 0) < 7);
      end
      drain();

      // Reset while the second beat is on the bus.
      send_one(1'b0);
      cnt0 = cpl_cnt;
      rand_fields(1'b0);
      drive(1'b1, 1'b1);
      drive(1'b0, 1'b1);
      chk("rstb1_in_beat1", 64'({bus_if.m_axis_tx_tvalid, bus_if.m_axis_tx_eop}), 64'd3);
      bus_if.m_axis_tx_tready = 1'b0;
      rst = 1'b1;
      eval();
      chk("rstb1_tvalid", 64'(bus_if.m_axis_tx_tvalid), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      drive(1'b0, 1'b1);
      drive(1'b0, 1'b1);
      chk("rstb1_no_inc", 64'(cpl_cnt), 64'd0);
      send_one(1'b1);
      chk("rstb1_resume", 64'(cpl_cnt), 64'd1);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
